// File: rtl/rx_cmd_sequencer.sv
// rx_cmd_sequencer
//   Sits between the UART byte receiver and the LED / 7-segment outputs. Received bytes are
//   queued in a small FIFO and executed one at a time, each decoded as {opcode, data}.
//   Display updates go to the seg7 driver over a req/ack handshake that is abandoned (and
//   counted as an error) if no ack arrives within ACK_TIMEOUT cycles.
//
// Parameters
//   DEPTH        FIFO entries, power of two, 2..16
//   ACK_TIMEOUT  cycles to wait for disp_ack before abandoning a display update, >= 1
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   rx_valid    in   one-cycle strobe, rx_byte holds a received byte
//   rx_byte     in   received byte {opcode[7:4], data[3:0]}
//   disp_ack    in   display driver has latched disp_digit / disp_clear
//   led         out  LED register
//   disp_digit  out  digit value to display (0..9)
//   disp_clear  out  blank-display request, qualified by disp_req
//   disp_req    out  display update pending
//   busy        out  sequencer not idle, or FIFO not empty
//   overflow    out  sticky, a byte was dropped because the FIFO was full
//   err_cnt     out  saturating count of illegal opcodes, digits > 9 and ack timeouts

module rx_cmd_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       disp_ack,
  output logic [7:0] led,
  output logic [3:0] disp_digit,
  output logic       disp_clear,
  output logic       disp_req,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [TW-1:0] TmoLast   = TW'(ACK_TIMEOUT - 1);

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLedLo = 4'h1;
  localparam logic [3:0] OpLedHi = 4'h2;
  localparam logic [3:0] OpLedX  = 4'h3;
  localparam logic [3:0] OpShow  = 4'h4;
  localparam logic [3:0] OpBlank = 4'h5;
  localparam logic [3:0] OpIncr  = 4'h6;
  localparam logic [3:0] OpClear = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StWaitAck
  } state_e;

  state_e        state;
  logic [7:0]    cmd_reg;
  logic [TW-1:0] tmo_cnt;

  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  logic [3:0]    cmd_op;
  logic [3:0]    cmd_data;

  assign cmd_op   = cmd_reg[7:4];
  assign cmd_data = cmd_reg[3:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The FIFO is only ever popped from FETCH, which is entered only when it holds an entry.
  assign pop  = (state == StFetch) && (count != '0);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push = rx_valid && ((count != FullCount) || pop);

  assign busy = (state != StIdle) || (count != '0);

  // ---------------------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      fifo_mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
      if (rx_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Command sequencer
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= StIdle;
      cmd_reg    <= '0;
      tmo_cnt    <= '0;
      led        <= '0;
      disp_digit <= '0;
      disp_clear <= 1'b0;
      disp_req   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (count != '0) begin
            state <= StFetch;
          end
        end

        StFetch: begin
          cmd_reg <= fifo_mem[rd_ptr];
          state   <= StExec;
        end

        StExec: begin
          state   <= StIdle;
          tmo_cnt <= '0;
          case (cmd_op)
            OpNop: begin
            end
            OpLedLo: led[3:0] <= cmd_data;
            OpLedHi: led[7:4] <= cmd_data;
            OpLedX:  led      <= led ^ {cmd_data, cmd_data};
            OpShow: begin
              if (cmd_data > 4'd9) begin
                err_cnt <= sat_inc(err_cnt);
              end else begin
                disp_digit <= cmd_data;
                disp_clear <= 1'b0;
                disp_req   <= 1'b1;
                state      <= StWaitAck;
              end
            end
            OpBlank: begin
              disp_clear <= 1'b1;
              disp_req   <= 1'b1;
              state      <= StWaitAck;
            end
            OpIncr: begin
              disp_digit <= (disp_digit == 4'd9) ? 4'd0 : disp_digit + 4'd1;
              disp_clear <= 1'b0;
              disp_req   <= 1'b1;
              state      <= StWaitAck;
            end
            OpClear: begin
              led        <= '0;
              disp_digit <= '0;
              disp_clear <= 1'b1;
              disp_req   <= 1'b1;
              state      <= StWaitAck;
            end
            default: err_cnt <= sat_inc(err_cnt);
          endcase
        end

        StWaitAck: begin
          // An ack on the final timeout cycle still counts as a successful handshake.
          if (disp_ack) begin
            disp_req <= 1'b0;
            state    <= StIdle;
          end else if (tmo_cnt == TmoLast) begin
            disp_req <= 1'b0;
            err_cnt  <= sat_inc(err_cnt);
            state    <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
module tb_rx_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       disp_ack;
  logic [7:0] led;
  logic [3:0] disp_digit;
  logic       disp_clear;
  logic       disp_req;
  logic       busy;
  logic       overflow;
  logic [7:0] err_cnt;

  always #5 clock = ~clock;

  rx_cmd_sequencer #(
    .DEPTH      (4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .disp_ack  (disp_ack),
    .led       (led),
    .disp_digit(disp_digit),
    .disp_clear(disp_clear),
    .disp_req  (disp_req),
    .busy      (busy),
    .overflow  (overflow),
    .err_cnt   (err_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: architectural effect of every executed command.
  logic [7:0] m_led;
  logic [3:0] m_digit;
  logic       m_clear;
  logic [7:0] m_err;
  logic       m_ovf;

  logic [7:0] burst [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mdl_reset();
    m_led   = 8'h00;
    m_digit = 4'h0;
    m_clear = 1'b0;
    m_err   = 8'h00;
    m_ovf   = 1'b0;
  endtask

  task automatic mdl_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // Applies one command byte; acked tells whether a display handshake got its ack.
  task automatic mdl_apply(input logic [7:0] b, input bit acked);
    logic [3:0] op;
    logic [3:0] d;
    bit         hs;
    op = b[7:4];
    d  = b[3:0];
    hs = 1'b0;
    case (op)
      4'h0: begin end
      4'h1: m_led[3:0] = d;
      4'h2: m_led[7:4] = d;
      4'h3: m_led = m_led ^ {d, d};
      4'h4: begin
        if (int'(d) > 9) mdl_err();
        else begin
          m_digit = d;
          m_clear = 1'b0;
          hs      = 1'b1;
        end
      end
      4'h5: begin
        m_clear = 1'b1;
        hs      = 1'b1;
      end
      4'h6: begin
        m_digit = 4'((int'(m_digit) + 1) % 10);
        m_clear = 1'b0;
        hs      = 1'b1;
      end
      4'hF: begin
        m_led   = 8'h00;
        m_digit = 4'h0;
        m_clear = 1'b1;
        hs      = 1'b1;
      end
      default: mdl_err();
    endcase
    if (hs && !acked) mdl_err();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_led"},   32'(led),        32'(m_led));
    chk({tag, "_digit"}, 32'(disp_digit), 32'(m_digit));
    chk({tag, "_clear"}, 32'(disp_clear), 32'(m_clear));
    chk({tag, "_req"},   32'(disp_req),   32'(0));
    chk({tag, "_err"},   32'(err_cnt),    32'(m_err));
    chk({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    chk({tag, "_busy"},  32'(busy),       32'(0));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Runs until idle, acking each display request ack_dly cycles after it is first seen
  // (ack_dly == 0 never acks). req_len returns the longest observed req pulse.
  task automatic drain(input int ack_dly, output int req_len);
    int cyc;
    int rc;
    bit done;
    cyc     = 0;
    rc      = 0;
    done    = 1'b0;
    req_len = 0;
    while (!done && cyc < 300) begin
      if (!busy && !disp_req) begin
        done = 1'b1;
      end else begin
        if (disp_req) rc++;
        else rc = 0;
        if (rc > req_len) req_len = rc;
        disp_ack = disp_req && (ack_dly > 0) && (rc == ack_dly);
        tick();
        cyc++;
      end
    end
    disp_ack = 1'b0;
    chk("drain_done", 32'(done), 32'(1));
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] b, input int ack_dly,
                         output int req_len);
    send_byte(b);
    drain(ack_dly, req_len);
    mdl_apply(b, ack_dly != 0);
    check_all(tag);
  endtask

  initial begin
    int len;
    int dly;
    logic [7:0] b;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    disp_ack = 1'b0;
    burst[0] = 8'h21;
    burst[1] = 8'h12;
    burst[2] = 8'h34;
    burst[3] = 8'h41;
    burst[4] = 8'h17;
    burst[5] = 8'h18;
    mdl_reset();

    // Reset held for two cycles.
    tick();
    tick();
    reset_n = 1'b1;
    check_all("reset");

    // LED latency: effect visible after the third edge following the push.
    send_byte(8'h1A);
    chk("lat_busy", 32'(busy), 32'(1));
    chk("lat_n0", 32'(led), 32'(0));
    tick();
    chk("lat_n1", 32'(led), 32'(0));
    tick();
    chk("lat_n2", 32'(led), 32'(0));
    tick();
    chk("lat_n3", 32'(led), 32'(8'h0A));
    drain(1, len);
    mdl_apply(8'h1A, 1'b1);
    run_cmd("led5a", 8'h25, 1, len);
    run_cmd("leda5", 8'h3F, 1, len);

    // Ack with no request pending is ignored.
    disp_ack = 1'b1;
    tick();
    tick();
    disp_ack = 1'b0;
    check_all("stray_ack");

    // Show digit 7, ack two cycles after req.
    send_byte(8'h47);
    tick();
    tick();
    chk("req_n2", 32'(disp_req), 32'(0));
    tick();
    chk("req_n3", 32'(disp_req), 32'(1));
    chk("show_digit_held", 32'(disp_digit), 32'(7));
    drain(2, len);
    chk("show_req_len", 32'(len), 32'(2));
    mdl_apply(8'h47, 1'b1);
    check_all("show7");

    // Illegal digit: error, no handshake.
    run_cmd("bad_digit", 8'h4C, 1, len);
    chk("bad_digit_noreq", 32'(len), 32'(0));

    // Increment wraps 9 -> 0.
    run_cmd("show9", 8'h49, 1, len);
    run_cmd("wrap", 8'h69, 1, len);

    // Six pushes while stalled in WAIT_ACK: four stored, two dropped.
    send_byte(8'h43);
    tick();
    tick();
    tick();
    chk("stall_req", 32'(disp_req), 32'(1));
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_byte  = burst[i];
      tick();
    end
    rx_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'(1));
    drain(1, len);
    mdl_apply(8'h43, 1'b1);
    for (int i = 0; i < 4; i++) mdl_apply(burst[i], 1'b1);
    m_ovf = 1'b1;
    check_all("ovf");

    // Blank with no ack: times out after 8 cycles.
    run_cmd("timeout", 8'h50, 0, len);
    chk("timeout_len", 32'(len), 32'(8));

    // Reset in the middle of a handshake.
    send_byte(8'h45);
    tick();
    tick();
    tick();
    chk("mid_req", 32'(disp_req), 32'(1));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mdl_reset();
    check_all("mid_reset");

    // Illegal opcode leaves LEDs alone.
    run_cmd("pre80", 8'h1C, 1, len);
    run_cmd("op80", 8'h80, 1, len);

    // Random commands, random ack delay (0 = let it time out).
    for (int i = 0; i < 40; i++) begin
      b   = 8'($urandom);
      dly = int'($urandom_range(4, 0));
      run_cmd("rand", b, dly, len);
    end

    // Saturate the error counter with illegal opcodes.
    for (int i = 0; i < 260; i++) begin
      b = {4'($urandom_range(14, 7)), 4'($urandom)};
      run_cmd("sat", b, 1, len);
    end
    chk("sat_final", 32'(err_cnt), 32'(8'hFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
